debounce_array: RTL and testbench
=================================

Name: debounce_array

Overview:
Multi-channel, parametrised push-button conditioner that sits between board switch pins and the processor's control/IO logic. Each channel synchronises its raw input and requires an exact, programmable number of stable cycles before accepting a level change. It then emits the clean level, one-cycle press/release pulses and a one-cycle long-press pulse. Polarity is selectable so active-low board buttons present as active-high "pressed".

Parameters:
CHANNELS, 4, number of independent button channels (>=1)
STABLE_CYCLES, 2048, consecutive differing sampled cycles required to accept a change (>=1)
LONG_CYCLES, 0, cycles the debounced level must stay pressed before long_pulse; 0 disables long-press logic
ACTIVE_LOW, 0, 1 = raw input is inverted at entry (pin low = pressed)

Ports:
clk  input  1  system clock
n_reset  input  1  synchronous, active-low reset
button_in  input  CHANNELS  raw asynchronous button pins
db_level  output  CHANNELS  debounced pressed level per channel (1 = pressed)
press_pulse  output  CHANNELS  one-cycle pulse when db_level rises
release_pulse  output  CHANNELS  one-cycle pulse when db_level falls
long_pulse  output  CHANNELS  one-cycle pulse when pressed for LONG_CYCLES
any_event  output  1  OR of all press_pulse and release_pulse bits, same cycle

Behaviour:
- Reset: n_reset is sampled on the clk rising edge; reset is synchronous and active-low.
- While n_reset = 0, every register clears: sync stages, counters, db_level, all pulses and any_event are 0.
- Reset mid-count discards progress. The first post-reset decision needs a full STABLE_CYCLES run.
- Entry: in = button_in XOR ACTIVE_LOW, per bit. It then passes through two flops, s1 then s2. Only s2 is used downstream.
- Stability counter: per channel, width clog2(STABLE_CYCLES+1).
  - If s2 == db_level: counter clears to 0.
  - If s2 != db_level and counter < STABLE_CYCLES-1: counter increments.
  - If s2 != db_level and counter == STABLE_CYCLES-1: db_level <= s2 and counter <= 0.
  - On that acceptance edge, press_pulse (for 0->1) or release_pulse (for 1->0) is registered high for exactly one cycle.
- Latency: input changes before edge k and stays stable. Then db_level and the pulse update at edge k+1+STABLE_CYCLES.
- Glitch rejection: a glitch that reverts before acceptance clears the counter. No output change occurs.
- No partial credit: the counter never decrements. Any single matching sample restarts the count from 0.
- Long press, when LONG_CYCLES > 0:
  - A per-channel hold counter, width clog2(LONG_CYCLES+1), clears while db_level = 0.
  - While db_level = 1 it increments, saturating at LONG_CYCLES.
  - long_pulse is high for one cycle on the edge where the counter goes from LONG_CYCLES-1 to LONG_CYCLES.
  - Fires once per press. Release and re-press re-arms it.
- Long press, when LONG_CYCLES = 0: long_pulse is tied 0 and no hold logic is generated.
- Channels are fully independent. Simultaneous acceptance on several channels produces simultaneous pulses.
- any_event is combinational OR of the registered pulse vectors. It is high if any channel pulses.
- press_pulse and release_pulse on one channel are mutually exclusive by construction.
- No output is X after the first reset edge.

Test Plan:
- STABLE_CYCLES=8, CHANNELS=4. Ch0 steps 0->1 before edge 10 -> db_level[0]=1 and press_pulse[0]=1 at edge 19 only; any_event=1 at edge 19 only; other channels stay 0.
- Ch1 bounces 1,0,1,0 at 3-cycle spacing, then holds 1 -> no pulses during bounce; press_pulse[1] exactly 9 cycles after the final stable edge.
- Ch2 pressed, then a 5-cycle low glitch -> db_level[2] stays 1 and no release_pulse. Then low for 8+ cycles -> a single release_pulse.
- LONG_CYCLES=20. Ch3 held pressed 40 cycles -> long_pulse[3] once, 20 cycles after press_pulse[3]. Release and re-press -> fires once again.
- n_reset=0 for 1 cycle at count 6 of 8 while input held 1 -> all outputs 0. Acceptance occurs 8 stable cycles after reset release, not 2.
- ACTIVE_LOW=1. All pins held 1 from reset -> all db_level stay 0. Ch0 pin driven 0 -> press_pulse[0] after 1+STABLE_CYCLES edges.

Source files
------------

// File: rtl/debounce_array_if.sv
// Button conditioner bus: raw pins in, debounced level and event pulses out.
interface debounce_array_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] button_in;
    logic [CHANNELS-1:0] db_level;
    logic [CHANNELS-1:0] press_pulse;
    logic [CHANNELS-1:0] release_pulse;
    logic [CHANNELS-1:0] long_pulse;
    logic                any_event;

    modport master (
        output button_in,
        input  db_level, press_pulse, release_pulse, long_pulse, any_event
    );

    modport slave (
        input  button_in,
        output db_level, press_pulse, release_pulse, long_pulse, any_event
    );
endinterface

// File: rtl/debounce_array.sv
// Multi-channel push-button debouncer: two-flop synchroniser, exact-count
// stability filter, press/release pulses and an optional long-press pulse.
module debounce_array #(
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = 2048,
    parameter int LONG_CYCLES   = 0,
    parameter bit ACTIVE_LOW    = 1'b0
) (
    input logic             clk,
    input logic             n_reset,
    debounce_array_if.slave bus
);
    localparam int            CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [CHANNELS-1:0] s1_q, s1_d;
    logic [CHANNELS-1:0] s2_q, s2_d;
    logic [CHANNELS-1:0] level_q, level_d;
    logic [CHANNELS-1:0] press_q, press_d;
    logic [CHANNELS-1:0] release_q, release_d;
    logic [CW-1:0]       cnt_q [CHANNELS];
    logic [CW-1:0]       cnt_d [CHANNELS];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        s1_d      = bus.button_in ^ {CHANNELS{ACTIVE_LOW}};
        s2_d      = s1_q;
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = '0;
            // Any sample agreeing with the current level restarts the run.
            if (s2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i]   = s2_q[i];
                    press_d[i]   = s2_q[i];
                    release_d[i] = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
        if (!n_reset) begin
            s1_q      <= '0;
            s2_q      <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    generate
        if (LONG_CYCLES > 0) begin : g_long
            localparam int            HW       = $clog2(LONG_CYCLES + 1);
            localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);
            localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_CYCLES - 1);

            logic [HW-1:0]       hold_q [CHANNELS];
            logic [HW-1:0]       hold_d [CHANNELS];
            logic [CHANNELS-1:0] long_q, long_d;

            // Hold time saturates, so the pulse fires once per press.
            always_comb begin
                long_d = '0;
                for (int i = 0; i < CHANNELS; i++) begin
                    hold_d[i] = '0;
                    if (level_q[i]) begin
                        hold_d[i] = (hold_q[i] == HOLD_MAX) ? hold_q[i] : hold_q[i] + 1'b1;
                        long_d[i] = (hold_q[i] == HOLD_PRE);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!n_reset) begin
                    long_q <= '0;
                    for (int i = 0; i < CHANNELS; i++) hold_q[i] <= '0;
                end else begin
                    long_q <= long_d;
                    for (int i = 0; i < CHANNELS; i++) hold_q[i] <= hold_d[i];
                end
            end

            assign bus.long_pulse = long_q;
        end else begin : g_no_long
            assign bus.long_pulse = '0;
        end
    endgenerate

    assign bus.db_level      = level_q;
    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
    assign bus.any_event     = (|press_q) | (|release_q);
endmodule

// File: tb/tb_debounce_array.sv
// Bench for debounce_array: directed scenarios plus random pin activity on an
// active-high long-press instance and an active-low instance, against a run-length model.
module tb_debounce_array;
    localparam int S = 8;
    localparam int L = 20;

    logic clk = 1'b0;
    logic n_reset;
    always #5 clk = ~clk;

    debounce_array_if #(.CHANNELS(4)) a_if ();
    debounce_array_if #(.CHANNELS(4)) b_if ();

    debounce_array #(.CHANNELS(4), .STABLE_CYCLES(S), .LONG_CYCLES(L), .ACTIVE_LOW(1'b0)) dut_a (
        .clk(clk), .n_reset(n_reset), .bus(a_if.slave)
    );
    debounce_array #(.CHANNELS(4), .STABLE_CYCLES(S), .LONG_CYCLES(0), .ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .n_reset(n_reset), .bus(b_if.slave)
    );

    // Expected state: synchroniser samples, accepted level, length of the current
    // disagreeing run, time spent pressed, and this cycle's events.
    typedef struct packed {
        logic [3:0]       s1, s2, level, press, rel, lng;
        logic [3:0][15:0] run, hold;
    } model_t;

    model_t ma, mb;
    int tests = 0;
    int fails = 0;
    int edge_n = 0;

    function automatic model_t model_next(model_t m, logic rst_n, logic [3:0] pins, bit al, int long_c);
        model_t n = m;
        if (!rst_n) return '0;
        n.press = '0;
        n.rel   = '0;
        n.lng   = '0;
        for (int ch = 0; ch < 4; ch++) begin
            if (long_c > 0 && m.level[ch]) begin
                if (m.hold[ch] < 16'(long_c)) n.hold[ch] = m.hold[ch] + 16'd1;
                if (m.hold[ch] == 16'(long_c - 1)) n.lng[ch] = 1'b1;
            end else begin
                n.hold[ch] = '0;
            end
            if (m.s2[ch] != m.level[ch]) begin
                n.run[ch] = m.run[ch] + 16'd1;
                if (n.run[ch] == 16'(S)) begin
                    n.level[ch] = m.s2[ch];
                    n.run[ch]   = '0;
                    if (m.s2[ch]) n.press[ch] = 1'b1;
                    else          n.rel[ch]   = 1'b1;
                end
            end else begin
                n.run[ch] = '0;
            end
        end
        n.s1 = pins ^ {4{al}};
        n.s2 = m.s1;
        return n;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        ma = model_next(ma, n_reset, a_if.button_in, 1'b0, L);
        mb = model_next(mb, n_reset, b_if.button_in, 1'b1, 0);
        edge_n++;
        #1;
        check("a_level",   a_if.db_level,      ma.level);
        check("a_press",   a_if.press_pulse,   ma.press);
        check("a_release", a_if.release_pulse, ma.rel);
        check("a_long",    a_if.long_pulse,    ma.lng);
        check("a_any",     a_if.any_event,     (|ma.press) | (|ma.rel));
        check("b_level",   b_if.db_level,      mb.level);
        check("b_press",   b_if.press_pulse,   mb.press);
        check("b_release", b_if.release_pulse, mb.rel);
        check("b_long",    b_if.long_pulse,    mb.lng);
        check("b_any",     b_if.any_event,     (|mb.press) | (|mb.rel));
    endtask

    // sel: 0 a press, 1 a release, 2 a long, 3 b press. at stays -1 on timeout.
    task automatic watch(input int sel, input int ch, input int bound, output int at);
        logic hit;
        at = -1;
        for (int i = 0; i < bound && at < 0; i++) begin
            step();
            case (sel)
                0:       hit = a_if.press_pulse[ch];
                1:       hit = a_if.release_pulse[ch];
                2:       hit = a_if.long_pulse[ch];
                default: hit = b_if.press_pulse[ch];
            endcase
            if (hit) at = edge_n;
        end
    endtask

    initial begin
        int k, at, p, cnt;
        logic [3:0] bounce;
        ma = '0;
        mb = '0;
        n_reset = 1'b0;
        a_if.button_in = 4'h0;
        b_if.button_in = 4'hF;
        repeat (3) step();
        check("reset_level_a", a_if.db_level, 4'h0);
        check("reset_any_a",   a_if.any_event, 1'b0);

        n_reset = 1'b1;
        repeat (12) step();
        check("al_idle_level_b", b_if.db_level, 4'h0);

        // Single clean press on ch0.
        a_if.button_in[0] = 1'b1;
        k = edge_n + 1;
        watch(0, 0, 30, at);
        check("ch0_press_edge", at, k + 1 + S);
        check("ch0_only_level", a_if.db_level, 4'b0001);

        // Bouncing ch1 settles high.
        bounce = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            a_if.button_in[1] = bounce[i];
            repeat (3) step();
            check("ch1_bounce_level", a_if.db_level[1], 1'b0);
        end
        a_if.button_in[1] = 1'b1;
        k = edge_n + 1;
        watch(0, 1, 30, at);
        check("ch1_press_edge", at, k + 1 + S);

        // Short low glitch on pressed ch2 is rejected, a long low is accepted.
        a_if.button_in[2] = 1'b1;
        watch(0, 2, 30, at);
        a_if.button_in[2] = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) a_if.button_in[2] = 1'b1;
            step();
            if (a_if.release_pulse[2]) cnt++;
        end
        check("ch2_glitch_release", cnt, 0);
        check("ch2_glitch_level", a_if.db_level[2], 1'b1);
        a_if.button_in[2] = 1'b0;
        k = edge_n + 1;
        watch(1, 2, 30, at);
        check("ch2_release_edge", at, k + 1 + S);

        // Long press on ch3, once per press, re-armed by release.
        a_if.button_in[3] = 1'b1;
        watch(0, 3, 30, p);
        watch(2, 3, 40, at);
        check("ch3_long_first", at, p + L);
        cnt = 0;
        repeat (25) begin
            step();
            if (a_if.long_pulse[3]) cnt++;
        end
        check("ch3_long_once", cnt, 0);
        a_if.button_in[3] = 1'b0;
        watch(1, 3, 30, at);
        a_if.button_in[3] = 1'b1;
        watch(0, 3, 30, p);
        watch(2, 3, 40, at);
        check("ch3_long_second", at, p + L);

        // Reset while ch2 is at count 6 of 8 discards the run.
        a_if.button_in[2] = 1'b1;
        k = edge_n + 1;
        while (edge_n < k + 7) step();
        n_reset = 1'b0;
        step();
        check("midreset_level_a", a_if.db_level, 4'h0);
        check("midreset_pulses_a", {a_if.press_pulse, a_if.release_pulse, a_if.long_pulse}, 12'h0);
        n_reset = 1'b1;
        watch(0, 2, 40, at);
        check("midreset_accept_edge", at, k + 18);

        // Active-low instance: pin driven low reads as pressed.
        b_if.button_in[0] = 1'b0;
        k = edge_n + 1;
        watch(3, 0, 30, at);
        check("b_ch0_press_edge", at, k + 1 + S);
        check("b_ch0_only_level", b_if.db_level, 4'b0001);

        // Random pin activity, alternating busy and calm phases, rare resets.
        for (int ph = 0; ph < 4; ph++) begin
            repeat (300) begin
                for (int c = 0; c < 4; c++) begin
                    if ($urandom_range(ph[0] ? 39 : 7, 0) == 0) a_if.button_in[c] = ~a_if.button_in[c];
                    if ($urandom_range(ph[0] ? 39 : 7, 0) == 0) b_if.button_in[c] = ~b_if.button_in[c];
                end
                n_reset = ($urandom_range(249, 0) != 0);
                step();
            end
        end
        n_reset = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
